// File: rtl/seq_chunk_add.sv
// Multi-cycle adder: adds two WIDTH-bit operands CHUNK bits per clock with a registered ripple carry.
// Define SEQ_CHUNK_ADD_SUB_EN to add the sub port (a - b via inverted b and forced carry-in).
module seq_chunk_add #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CHUNK = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SEQ_CHUNK_ADD_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);

    localparam int unsigned N  = WIDTH / CHUNK;
    localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res_sh;
    logic             carry;
    logic [CW-1:0]    cnt;

    logic [CHUNK-1:0] chunk_sum;
    logic [CHUNK:0]   chunk_c;
    logic [WIDTH-1:0] res_next;
    logic             last;
    logic [WIDTH-1:0] b_load;
    logic             c_load;

    // Bit-level ripple so the carry into the chunk MSB is visible for overflow.
    always_comb begin
        chunk_c    = '0;
        chunk_sum  = '0;
        chunk_c[0] = carry;
        for (int unsigned i = 0; i < CHUNK; i++) begin
            chunk_sum[i]   = a_sh[i] ^ b_sh[i] ^ chunk_c[i];
            chunk_c[i+1]   = (a_sh[i] & b_sh[i]) | (chunk_c[i] & (a_sh[i] ^ b_sh[i]));
        end
    end

    always_comb begin
        res_next = (res_sh >> CHUNK) | (WIDTH'(chunk_sum) << (WIDTH - CHUNK));
        last     = (cnt == CW'(N - 1));
    end

`ifdef SEQ_CHUNK_ADD_SUB_EN
    always_comb begin
        b_load = sub ? ~b : b;
        c_load = sub ? 1'b1 : cin;
    end
`else
    always_comb begin
        b_load = b;
        c_load = cin;
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            a_sh     <= '0;
            b_sh     <= '0;
            res_sh   <= '0;
            carry    <= 1'b0;
            cnt      <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            sum      <= '0;
            cout     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_sh   <= a;
                        b_sh   <= b_load;
                        carry  <= c_load;
                        res_sh <= '0;
                        cnt    <= '0;
                        busy   <= 1'b1;
                        state  <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    a_sh   <= a_sh >> CHUNK;
                    b_sh   <= b_sh >> CHUNK;
                    res_sh <= res_next;
                    carry  <= chunk_c[CHUNK];
                    cnt    <= cnt + CW'(1);
                    if (last) begin
                        sum      <= res_next;
                        cout     <= chunk_c[CHUNK];
                        overflow <= chunk_c[CHUNK] ^ chunk_c[CHUNK-1];
                        done     <= 1'b1;
                        busy     <= 1'b0;
                        state    <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_chunk_add.sv
// Directed self-checking bench for seq_chunk_add (WIDTH=8, CHUNK=2, N=4).
module tb_seq_chunk_add;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
`ifdef SEQ_CHUNK_ADD_SUB_EN
    logic       sub;
`endif
    logic       busy;
    logic       done;
    logic [7:0] sum;
    logic       cout;
    logic       overflow;

    int vectors    = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    seq_chunk_add #(.WIDTH(8), .CHUNK(2)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .a        (a),
        .b        (b),
        .cin      (cin),
`ifdef SEQ_CHUNK_ADD_SUB_EN
        .sub      (sub),
`endif
        .busy     (busy),
        .done     (done),
        .sum      (sum),
        .cout     (cout),
        .overflow (overflow)
    );

    // Pulses start for one cycle; returns busy just after acceptance and cycles until done (-1 on timeout).
    task automatic run_op(input logic [7:0] ta, input logic [7:0] tb_v, input logic tc,
                          output logic busy_acc, output int lat);
        @(negedge clk);
        a = ta; b = tb_v; cin = tc; start = 1'b1;
        @(posedge clk); #1;
        start    = 1'b0;
        busy_acc = busy;
        lat      = -1;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            if (done) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            start = 1'($urandom); a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom);
`ifdef SEQ_CHUNK_ADD_SUB_EN
            sub = 1'($urandom);
`endif
        end
        @(negedge clk);
        vectors++;
        if ({busy, done, sum, cout, overflow} !== 12'h000) begin
            miscompares++;
            $display("FAIL reset: busy=%b done=%b sum=%h cout=%b ovf=%b, required all 0",
                     busy, done, sum, cout, overflow);
        end
        start = 1'b0; cin = 1'b0;
`ifdef SEQ_CHUNK_ADD_SUB_EN
        sub = 1'b0;
`endif
        rst_n = 1'b1;
    endtask

    task automatic check_op(input string name, input logic [7:0] ta, input logic [7:0] tb_v,
                            input logic tc, input logic [7:0] es, input logic ec, input logic eo);
        logic busy_acc;
        int   lat;
        run_op(ta, tb_v, tc, busy_acc, lat);
        vectors++;
        if (busy_acc !== 1'b1) begin
            miscompares++;
            $display("FAIL %s busy_after_accept: got %b, required 1", name, busy_acc);
        end
        vectors++;
        if (lat != 4) begin
            miscompares++;
            $display("FAIL %s latency: got %0d, required 4", name, lat);
        end
        vectors++;
        if ({sum, cout, overflow, busy} !== {es, ec, eo, 1'b0}) begin
            miscompares++;
            $display("FAIL %s result: sum=%h cout=%b ovf=%b busy=%b, required sum=%h cout=%b ovf=%b busy=0",
                     name, sum, cout, overflow, busy, es, ec, eo);
        end
        @(posedge clk); #1;
        vectors++;
        if (done !== 1'b0) begin
            miscompares++;
            $display("FAIL %s done_pulse_width: done=%b one cycle later, required 0", name, done);
        end
    endtask

    task automatic test_add();
        check_op("ff_plus_01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
        check_op("7f_plus_01_c", 8'h7F, 8'h01, 1'b1, 8'h81, 1'b0, 1'b1);
        check_op("80_plus_80", 8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1);
    endtask

    // Previous result is 8'h00 from 80+80; edge numbers are relative to acceptance edge k.
    task automatic test_back_to_back();
        @(negedge clk);
        a = 8'h12; b = 8'h34; cin = 1'b0; start = 1'b1;
        @(posedge clk); #1;                     // k
        start = 1'b0;
        @(posedge clk); #1;                     // k+1
        a = 8'hAA; b = 8'h55; start = 1'b1;
        @(posedge clk); #1;                     // k+2
        start = 1'b0;
        vectors++;
        if ({busy, done, sum} !== {1'b1, 1'b0, 8'h00}) begin
            miscompares++;
            $display("FAIL b2b_stable_during_run: busy=%b done=%b sum=%h, required busy=1 done=0 sum=00",
                     busy, done, sum);
        end
        @(posedge clk); #1;                     // k+3
        a = 8'h01; b = 8'h02; start = 1'b1;
        @(posedge clk); #1;                     // k+4
        vectors++;
        if ({done, busy, sum, cout, overflow} !== {1'b1, 1'b0, 8'h46, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL b2b_first_result: done=%b busy=%b sum=%h cout=%b ovf=%b, required done=1 busy=0 sum=46 cout=0 ovf=0",
                     done, busy, sum, cout, overflow);
        end
        @(posedge clk); #1;                     // k+5
        start = 1'b0;
        vectors++;
        if ({busy, done} !== 2'b10) begin
            miscompares++;
            $display("FAIL b2b_accept_in_done: busy=%b done=%b, required busy=1 done=0", busy, done);
        end
        repeat (3) @(posedge clk);              // k+8
        #1;
        vectors++;
        if (done !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_early_done: done=%b at k+8, required 0", done);
        end
        @(posedge clk); #1;                     // k+9
        vectors++;
        if ({done, sum} !== {1'b1, 8'h03}) begin
            miscompares++;
            $display("FAIL b2b_second_result: done=%b sum=%h, required done=1 sum=03", done, sum);
        end
    endtask

    task automatic test_reset_mid_run();
        logic saw_done = 1'b0;
        int   lat = -1;
        @(negedge clk);
        a = 8'h11; b = 8'h22; cin = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({busy, done, sum, cout, overflow} !== 12'h000) begin
            miscompares++;
            $display("FAIL midrun_reset_outputs: busy=%b done=%b sum=%h cout=%b ovf=%b, required all 0",
                     busy, done, sum, cout, overflow);
        end
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (done) saw_done = 1'b1;
        end
        @(negedge clk);
        rst_n = 1'b1;
        a = 8'h10; b = 8'h20; cin = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        vectors++;
        if ({saw_done, busy} !== 2'b01) begin
            miscompares++;
            $display("FAIL midrun_reset_restart: saw_done=%b busy=%b, required saw_done=0 busy=1",
                     saw_done, busy);
        end
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            if (done) begin
                lat = i;
                break;
            end
        end
        vectors++;
        if (lat != 4 || sum !== 8'h30) begin
            miscompares++;
            $display("FAIL midrun_reset_result: latency=%0d sum=%h, required latency=4 sum=30", lat, sum);
        end
    endtask

`ifdef SEQ_CHUNK_ADD_SUB_EN
    task automatic test_sub();
        sub = 1'b1;
        check_op("sub_05_07", 8'h05, 8'h07, 1'b0, 8'hFE, 1'b0, 1'b0);
        check_op("sub_80_01", 8'h80, 8'h01, 1'b0, 8'h7F, 1'b1, 1'b1);
        sub = 1'b0;
        check_op("sub0_add", 8'h05, 8'h07, 1'b1, 8'h0D, 1'b0, 1'b0);
    endtask
`endif

    initial begin
        start = 1'b0; a = '0; b = '0; cin = 1'b0;
`ifdef SEQ_CHUNK_ADD_SUB_EN
        sub = 1'b0;
`endif
        rst_n = 1'b1;
        test_reset();
        test_add();
        test_back_to_back();
        test_reset_mid_run();
`ifdef SEQ_CHUNK_ADD_SUB_EN
        test_sub();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish, required completion");
        $fatal(1);
    end

endmodule
